// File: rtl/rng_pkg.sv
// Shared types and constants for the LFSR random stream: FSM encoding,
// default polynomial/seed and the single-precision fields used by float output.
package rng_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_VALID = 2'd2
  } rng_state_e;

  // Taps 31,21,1,0 give a maximal-length 32-bit sequence
  localparam logic [31:0] DEF_TAP_MASK   = 32'h8020_0003;
  localparam logic [31:0] DEF_RESET_SEED = 32'hF23A_27BB;

  localparam logic [7:0] FLT_EXP_BIAS = 8'd127;
  localparam int         FLT_MANT_W   = 23;

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR advance: shift left, feedback = XOR of tapped bits.
// Zero latency; no handshake.
module lfsr_step #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(32'h8020_0003)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_nxt
);

  always_comb begin
    state_nxt = {state[WIDTH-2:0], ^(state & TAP_MASK)};
  end

endmodule

// File: rtl/lfsr_rng_stream.sv
// LFSR random word stream with seed load, leap stepping and zero-seed recovery; first word
// STEPS_PER_OUT cycles after enable, words held while rand_ready=0. RNG_FLOAT_OUT_EN selects float output.
module lfsr_rng_stream
  import rng_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] TAP_MASK      = LFSR_WIDTH'(DEF_TAP_MASK),
  parameter logic [LFSR_WIDTH-1:0] RESET_SEED    = LFSR_WIDTH'(DEF_RESET_SEED),
  parameter int                    STEPS_PER_OUT = 1,
  parameter int                    OUTPUT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    enable,
  input  logic                    seed_load,
  input  logic [LFSR_WIDTH-1:0]   seed_data,
  output logic                    rand_valid,
  input  logic                    rand_ready,
  output logic [OUTPUT_WIDTH-1:0] rand_data,
  output logic                    lockup_flag
);

  localparam int CNT_W = $clog2(STEPS_PER_OUT + 1);

  if (LFSR_WIDTH < 8) begin : g_bad_width
    $error("lfsr_rng_stream: LFSR_WIDTH must be >= 8");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_rng_stream: RESET_SEED must be non-zero");
  end
  if (STEPS_PER_OUT < 1 || STEPS_PER_OUT > LFSR_WIDTH) begin : g_bad_steps
    $error("lfsr_rng_stream: STEPS_PER_OUT out of range");
  end
  if (OUTPUT_WIDTH > LFSR_WIDTH) begin : g_bad_out
    $error("lfsr_rng_stream: OUTPUT_WIDTH exceeds LFSR_WIDTH");
  end
`ifdef RNG_FLOAT_OUT_EN
  if (OUTPUT_WIDTH != 32 || LFSR_WIDTH < FLT_MANT_W) begin : g_bad_float
    $error("lfsr_rng_stream: float output needs OUTPUT_WIDTH==32 and LFSR_WIDTH>=23");
  end
`endif

  rng_state_e            fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LFSR_WIDTH-1:0] state_q, state_d, state_nxt;
  logic                  lockup_q, lockup_d;
  logic                  do_step;

  lfsr_step #(
    .WIDTH    (LFSR_WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_step (
    .state     (state_q),
    .state_nxt (state_nxt)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      fsm_q    <= S_IDLE;
      cnt_q    <= '0;
      state_q  <= RESET_SEED;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  // Next FSM state and step counter; seed_load overrides everything
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    do_step = 1'b0;
    if (seed_load) begin
      fsm_d = S_IDLE;
      cnt_d = '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (enable) begin
            do_step = 1'b1;
            if (STEPS_PER_OUT == 1) begin
              fsm_d = S_VALID;
              cnt_d = '0;
            end else begin
              fsm_d = S_STEP;
              cnt_d = CNT_W'(1);
            end
          end
        end
        S_STEP: begin
          if (enable) begin
            do_step = 1'b1;
            if (cnt_q == CNT_W'(STEPS_PER_OUT - 1)) begin
              fsm_d = S_VALID;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_VALID: begin
          if (rand_ready) begin
            if (enable) begin
              do_step = 1'b1;
              if (STEPS_PER_OUT == 1) begin
                cnt_d = '0;
              end else begin
                fsm_d = S_STEP;
                cnt_d = CNT_W'(1);
              end
            end else begin
              fsm_d = S_IDLE;
              cnt_d = '0;
            end
          end
        end
        default: begin
          fsm_d = S_IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  // A zero seed would lock the register at zero, so it is swapped for RESET_SEED and flagged
  always_comb begin
    state_d  = state_q;
    lockup_d = lockup_q;
    if (seed_load) begin
      if (seed_data == '0) begin
        state_d  = RESET_SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_data;
      end
    end else if (do_step) begin
      state_d = state_nxt;
    end
  end

  always_comb begin
    rand_valid  = (fsm_q == S_VALID);
    lockup_flag = lockup_q;
`ifdef RNG_FLOAT_OUT_EN
    rand_data   = {1'b0, FLT_EXP_BIAS, state_q[FLT_MANT_W-1:0]};
`else
    rand_data   = state_q[OUTPUT_WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Directed bench: default instance (one step per word) and a leap instance (four steps per word).
module tb_lfsr_rng_stream;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        en, rdy, sl;
  logic [31:0] sd;
  logic        vld, lck;
  logic [31:0] dat;
  logic        en4, rdy4, sl4;
  logic [31:0] sd4;
  logic        vld4, lck4;
  logic [31:0] dat4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_rng_stream dut (
    .clk         (clk),
    .rstnn       (rstnn),
    .enable      (en),
    .seed_load   (sl),
    .seed_data   (sd),
    .rand_valid  (vld),
    .rand_ready  (rdy),
    .rand_data   (dat),
    .lockup_flag (lck)
  );

  lfsr_rng_stream #(.STEPS_PER_OUT(4)) dut4 (
    .clk         (clk),
    .rstnn       (rstnn),
    .enable      (en4),
    .seed_load   (sl4),
    .seed_data   (sd4),
    .rand_valid  (vld4),
    .rand_ready  (rdy4),
    .rand_data   (dat4),
    .lockup_flag (lck4)
  );

  // Reference polynomial: taps 31,21,1,0
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] s);
`ifdef RNG_FLOAT_OUT_EN
    return {1'b0, 8'd127, s[22:0]};
`else
    return s;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s;
  logic [31:0] s4;

  task automatic test_reset();
    rstnn = 1'b0;
    en = 1'b0; rdy = 1'b0; sl = 1'b0; sd = '0;
    en4 = 1'b0; rdy4 = 1'b0; sl4 = 1'b0; sd4 = '0;
    tick();
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vld); end
    checks++; if (lck !== 1'b0) begin errors++; $display("FAIL reset_lockup got %b want 0", lck); end
    checks++; if (dat !== fmt(32'hF23A_27BB)) begin errors++; $display("FAIL reset_data got %h want %h", dat, fmt(32'hF23A_27BB)); end
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b want 0", vld4); end
    rstnn = 1'b1;
    s  = 32'hF23A_27BB;
    s4 = 32'hF23A_27BB;
  endtask

  task automatic test_first_word();
    logic [31:0] want;
`ifdef RNG_FLOAT_OUT_EN
    want = 32'h3FF4_4F76;
`else
    want = 32'hE474_4F76;
`endif
    en = 1'b1; rdy = 1'b1;
    tick();
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", vld); end
    checks++; if (dat !== want) begin errors++; $display("FAIL first_data got %h want %h", dat, want); end
    s = 32'hE474_4F76;
    tick();
    s = lfsr_next(s);
    checks++; if (vld !== 1'b1 || dat !== fmt(s)) begin errors++; $display("FAIL back_to_back got %b/%h want 1/%h", vld, dat, fmt(s)); end
  endtask

  task automatic test_backpressure();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (vld !== 1'b1 || dat !== fmt(s)) begin errors++; $display("FAIL hold_%0d got %b/%h want 1/%h", i, vld, dat, fmt(s)); end
    end
    rdy = 1'b1;
    tick();
    s = lfsr_next(s);
    checks++; if (vld !== 1'b1 || dat !== fmt(s)) begin errors++; $display("FAIL release got %b/%h want 1/%h", vld, dat, fmt(s)); end
    en = 1'b0;
    tick();
    checks++; if (vld !== 1'b0 || dat !== fmt(s)) begin errors++; $display("FAIL idle_after_accept got %b/%h want 0/%h", vld, dat, fmt(s)); end
  endtask

  task automatic test_lockup();
    en = 1'b1; rdy = 1'b0;
    tick();
    s = lfsr_next(s);
    checks++; if (vld !== 1'b1 || dat !== fmt(s)) begin errors++; $display("FAIL pre_seed got %b/%h want 1/%h", vld, dat, fmt(s)); end
    en = 1'b0; sl = 1'b1; sd = 32'h0;
    tick();
    sl = 1'b0;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL zero_seed_valid got %b want 0", vld); end
    checks++; if (lck !== 1'b1) begin errors++; $display("FAIL zero_seed_lockup got %b want 1", lck); end
    checks++; if (dat !== fmt(32'hF23A_27BB)) begin errors++; $display("FAIL zero_seed_state got %h want %h", dat, fmt(32'hF23A_27BB)); end
    en = 1'b1; rdy = 1'b1;
    tick();
    checks++; if (vld !== 1'b1 || dat !== fmt(32'hE474_4F76)) begin errors++; $display("FAIL after_zero_seed got %b/%h want 1/%h", vld, dat, fmt(32'hE474_4F76)); end
    en = 1'b0; sl = 1'b1; sd = 32'h0000_0001;
    tick();
    sl = 1'b0; en = 1'b1;
    tick();
    checks++; if (vld !== 1'b1 || dat !== fmt(32'h0000_0003)) begin errors++; $display("FAIL seed_one got %b/%h want 1/%h", vld, dat, fmt(32'h0000_0003)); end
    checks++; if (lck !== 1'b1) begin errors++; $display("FAIL lockup_sticky got %b want 1", lck); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_leap();
    en4 = 1'b1; rdy4 = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        s4 = lfsr_next(s4);
        checks++; if (vld4 !== (k == 4)) begin errors++; $display("FAIL leap_valid_w%0d_c%0d got %b want %b", w, k, vld4, (k == 4)); end
      end
      checks++; if (dat4 !== fmt(s4)) begin errors++; $display("FAIL leap_data_w%0d got %h want %h", w, dat4, fmt(s4)); end
    end
    en4 = 1'b0;
    tick();
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL leap_idle got %b want 0", vld4); end
  endtask

  task automatic test_pause();
    logic [31:0] mid;
    en4 = 1'b1; rdy4 = 1'b1;
    tick();
    tick();
    mid = lfsr_next(lfsr_next(s4));
    en4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (vld4 !== 1'b0 || dat4 !== fmt(mid)) begin errors++; $display("FAIL pause_%0d got %b/%h want 0/%h", i, vld4, dat4, fmt(mid)); end
    end
    en4 = 1'b1;
    tick();
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL resume_early got %b want 0", vld4); end
    tick();
    s4 = lfsr_next(lfsr_next(mid));
    checks++; if (vld4 !== 1'b1 || dat4 !== fmt(s4)) begin errors++; $display("FAIL resume_word got %b/%h want 1/%h", vld4, dat4, fmt(s4)); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; rdy = 1'b1;
    tick();
    tick();
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL running_valid got %b want 1", vld); end
    rstnn = 1'b0;
    #2;
    checks++; if (vld !== 1'b0 || lck !== 1'b0) begin errors++; $display("FAIL async_reset got %b/%b want 0/0", vld, lck); end
    checks++; if (dat !== fmt(32'hF23A_27BB)) begin errors++; $display("FAIL async_reset_data got %h want %h", dat, fmt(32'hF23A_27BB)); end
    checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL async_reset_valid4 got %b want 0", vld4); end
    en = 1'b0; rdy = 1'b0; en4 = 1'b0; rdy4 = 1'b0;
    tick();
    rstnn = 1'b1;
    en = 1'b1; rdy = 1'b1;
    tick();
    checks++; if (vld !== 1'b1 || dat !== fmt(32'hE474_4F76)) begin errors++; $display("FAIL post_reset_word got %b/%h want 1/%h", vld, dat, fmt(32'hE474_4F76)); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_backpressure();
    test_lockup();
    test_leap();
    test_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
